// File: rtl/dmem_arb_pkg.sv
// Shared defaults and helpers for the dmem arbiter slice.
package dmem_arb_pkg;

  localparam int unsigned DEF_AW           = 12;
  localparam int unsigned DEF_DW           = 32;
  localparam int unsigned DEF_STARVE_LIMIT = 8;

  // Round-robin pointer width: clog2(n), never narrower than one bit.
  function automatic int unsigned ptrWidth(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr, wrapping.
module rr_pick
  import dmem_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned PW   = ptrWidth(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            any
);

  // Two passes replace a modulo index: indices >= ptr first, then the wrapped ones.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!any && req[i] && (i >= 32'(ptr))) begin
        gnt[i] = 1'b1;
        idx    = PW'(i);
        any    = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!any && req[i] && (i < 32'(ptr))) begin
        gnt[i] = 1'b1;
        idx    = PW'(i);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem arbiter: CPU priority, round-robin aux access, starvation-forced aux grant.
// Optional DMEM_ARB_STATS_EN adds stall_count and max_wait outputs.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned NREQ         = 2,
  parameter int unsigned AW           = DEF_AW,
  parameter int unsigned DW           = DEF_DW,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [DW-1:0]     cpu_wdata,
  output logic              cpu_stall,
  input  logic [NREQ-1:0]   aux_req,
  input  logic [NREQ-1:0]   aux_wen,
  input  logic [NREQ*AW-1:0] aux_addr,
  input  logic [NREQ*DW-1:0] aux_wdata,
  output logic [NREQ-1:0]   aux_gnt,
  output logic [NREQ-1:0]   aux_rvalid,
  output logic [DW-1:0]     rdata,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_wen,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       stall_count,
  output logic [7:0]        max_wait
`endif
);

  localparam int unsigned PW = ptrWidth(NREQ);

  logic [7:0]      starveCnt;
  logic [PW-1:0]   rrPtr;
  logic [NREQ-1:0] pickGnt;
  logic [PW-1:0]   pickIdx;
  logic            pickAny;
  logic            forceAux;
  logic            cpuGnt;
  logic            auxGnt;
  logic [AW-1:0]   heldAddr;
  logic [DW-1:0]   heldWdata;
  logic            pendRd;
  logic [NREQ-1:0] pendAux;

  rr_pick #(.NREQ(NREQ), .PW(PW)) uPick (
    .req (aux_req),
    .ptr (rrPtr),
    .gnt (pickGnt),
    .idx (pickIdx),
    .any (pickAny)
  );

  assign forceAux  = (starveCnt == 8'(STARVE_LIMIT)) && (|aux_req);
  assign cpuGnt    = !reset && cpu_req && !forceAux;
  assign auxGnt    = !reset && pickAny && !cpuGnt;
  assign aux_gnt   = auxGnt ? pickGnt : '0;
  assign cpu_stall = !reset && cpu_req && forceAux;

  // Idle cycles replay the last address/data so the dmem pins never toggle spuriously.
  always_comb begin
    mem_addr  = heldAddr;
    mem_wdata = heldWdata;
    mem_wen   = 1'b0;
    if (cpuGnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_wen   = cpu_wen;
    end else if (auxGnt) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (pickGnt[i]) begin
          mem_addr  = aux_addr[i*AW +: AW];
          mem_wdata = aux_wdata[i*DW +: DW];
          mem_wen   = aux_wen[i];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starveCnt  <= '0;
      rrPtr      <= '0;
      heldAddr   <= '0;
      heldWdata  <= '0;
      pendRd     <= 1'b0;
      pendAux    <= '0;
      aux_rvalid <= '0;
      rdata      <= '0;
    end else begin
      heldAddr  <= mem_addr;
      heldWdata <= mem_wdata;

      if (auxGnt || (aux_req == '0))
        starveCnt <= '0;
      else if (starveCnt != 8'(STARVE_LIMIT))
        starveCnt <= starveCnt + 8'd1;

      if (auxGnt)
        rrPtr <= (32'(pickIdx) == NREQ - 1) ? '0 : pickIdx + PW'(1);

      // dmem answers one cycle after the address; capture it on the following edge.
      pendRd     <= (cpuGnt || auxGnt) && !mem_wen;
      pendAux    <= (auxGnt && !mem_wen) ? pickGnt : '0;
      aux_rvalid <= pendAux;
      if (pendRd)
        rdata <= mem_rdata;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count <= '0;
      max_wait    <= '0;
    end else begin
      if (cpu_stall && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
      if (starveCnt > max_wait)
        max_wait <= starveCnt;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a write-first dmem model and a reference arbiter model.
module tb_dmem_arbiter;

  localparam int NREQ  = 2;
  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int LIMIT = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              cpu_req, cpu_wen;
  logic [AW-1:0]     cpu_addr;
  logic [DW-1:0]     cpu_wdata;
  logic              cpu_stall;
  logic [NREQ-1:0]   aux_req, aux_wen;
  logic [NREQ*AW-1:0] aux_addr;
  logic [NREQ*DW-1:0] aux_wdata;
  logic [NREQ-1:0]   aux_gnt, aux_rvalid;
  logic [DW-1:0]     rdata;
  logic [AW-1:0]     mem_addr;
  logic              mem_wen;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]       stall_count;
  logic [7:0]        max_wait;
`endif

  dmem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_wen    (cpu_wen),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .aux_req    (aux_req),
    .aux_wen    (aux_wen),
    .aux_addr   (aux_addr),
    .aux_wdata  (aux_wdata),
    .aux_gnt    (aux_gnt),
    .aux_rvalid (aux_rvalid),
    .rdata      (rdata),
    .mem_addr   (mem_addr),
    .mem_wen    (mem_wen),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stall_count(stall_count),
    .max_wait   (max_wait)
`endif
  );

  always #5 clock = ~clock;

  // Single-port write-first syncram driven by the DUT pins.
  logic [DW-1:0] mem    [4096];
  logic [DW-1:0] refMem [4096];

  always @(posedge clock) begin
    if (mem_wen) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem_wen ? mem_wdata : mem[mem_addr];
  end

  typedef struct {
    int              due;
    logic [NREQ-1:0] who;
    logic [DW-1:0]   data;
  } rdExp_t;

  rdExp_t        rq[$];
  int            nChecks = 0;
  int            nErrors = 0;
  int            cyc = 0;
  int            mStarve = 0;
  int            mPtr = 0;
  int            mStalls = 0;
  int            mMaxWait = 0;
  logic [AW-1:0] mLast = '0;
  bit            seenReset = 1'b0;

  task automatic checkVal(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic cycle();
    bit              forceAux, cpuG, auxG, eStall;
    int              idx, j;
    logic [NREQ-1:0] eGnt;
    logic            eWen;
    logic [AW-1:0]   eAddr;
    logic [DW-1:0]   eWdata;
    rdExp_t          e;

    @(negedge clock);
    cpuG = 0; auxG = 0; idx = 0; eGnt = '0; eWen = 1'b0; eAddr = mLast; eWdata = '0;
    forceAux = (mStarve == LIMIT) && (aux_req != '0);
    eStall   = !reset && cpu_req && forceAux;
    if (!reset) begin
      if (cpu_req && !forceAux) begin
        cpuG = 1; eWen = cpu_wen; eAddr = cpu_addr; eWdata = cpu_wdata;
      end else if (aux_req != '0) begin
        for (int k = 0; k < NREQ; k++) begin
          j = (mPtr + k) % NREQ;
          if (!auxG && aux_req[j]) begin auxG = 1; idx = j; end
        end
        eGnt[idx] = 1'b1;
        eWen   = aux_wen[idx];
        eAddr  = aux_addr[idx*AW +: AW];
        eWdata = aux_wdata[idx*DW +: DW];
      end
    end

    checkVal("aux_gnt", DW'(aux_gnt), DW'(eGnt));
    checkVal("cpu_stall", DW'(cpu_stall), DW'(eStall));
    checkVal("mem_wen", DW'(mem_wen), DW'(eWen));
    if (cpuG || auxG || seenReset) checkVal("mem_addr", DW'(mem_addr), DW'(eAddr));
    if (eWen) checkVal("mem_wdata", mem_wdata, eWdata);

    if (rq.size() > 0 && rq[0].due == cyc) begin
      e = rq.pop_front();
      checkVal("aux_rvalid", DW'(aux_rvalid), DW'(e.who));
      checkVal("rdata", rdata, e.data);
    end else if (seenReset) begin
      checkVal("aux_rvalid_idle", DW'(aux_rvalid), '0);
    end

    if (reset) rq.delete();
    else if ((cpuG || auxG) && !eWen) rq.push_back('{cyc + 2, eGnt, refMem[eAddr]});
    if ((cpuG || auxG) && eWen) refMem[eAddr] = eWdata;

    @(posedge clock);
    if (reset) begin
      mStarve = 0; mPtr = 0; mLast = '0; mStalls = 0; mMaxWait = 0; seenReset = 1'b1;
    end else begin
      if (mStarve > mMaxWait) mMaxWait = mStarve;
      if (eStall) mStalls++;
      if (auxG) begin
        mStarve = 0;
        mPtr = (idx + 1) % NREQ;
      end else if (aux_req == '0) begin
        mStarve = 0;
      end else if (mStarve < LIMIT) begin
        mStarve++;
      end
      if (cpuG || auxG) mLast = eAddr;
    end
    cyc++;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin mem[i] = '0; refMem[i] = '0; end
    mem[12'h040] = 32'hDEADBEEF;
    refMem[12'h040] = 32'hDEADBEEF;

    // Reset with every request asserted, then CPU wins the first free cycle.
    reset = 1'b1; cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    aux_req = '1; aux_wen = '0; aux_addr = '0; aux_wdata = '0;
    repeat (2) cycle();
    reset = 1'b0;
    cycle();
    checkVal("rdata_reset", rdata, '0);

    // Aux round robin on reads.
    cpu_req = 1'b0;
    aux_req = 2'b11;
    aux_addr = {12'h041, 12'h040};
    repeat (6) cycle();
    aux_req = '0;
    repeat (2) cycle();

    // Starvation: CPU requests continuously, aux0 pending.
    cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 12'h010;
    aux_req = 2'b01;
    repeat (28) cycle();

    // Aux write, idle cycle, CPU read back.
    cpu_req = 1'b0;
    aux_req = 2'b01; aux_wen = 2'b01;
    aux_addr = {12'h000, 12'h100}; aux_wdata = {32'h0, 32'h5};
    cycle();
    aux_req = '0; aux_wen = '0;
    cycle();
    cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 12'h100;
    cycle();
    cpu_req = 1'b0;
    repeat (2) cycle();

    // CPU write then aux read of the same address.
    cpu_req = 1'b1; cpu_wen = 1'b1; cpu_addr = 12'h200; cpu_wdata = 32'hCAFEF00D;
    cycle();
    cpu_req = 1'b0; cpu_wen = 1'b0;
    aux_req = 2'b10; aux_addr = {12'h200, 12'h000};
    cycle();
    aux_req = '0;
    repeat (2) cycle();

    // Reset lands while an aux read return is in flight.
    aux_req = 2'b01; aux_addr = {12'h000, 12'h040};
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0; aux_req = '0;
    repeat (2) cycle();
    checkVal("rdata_midop_reset", rdata, '0);

    // Random traffic over a small address window.
    repeat (300) begin
      cpu_req   = 1'($urandom_range(0, 1));
      cpu_wen   = 1'($urandom_range(0, 1));
      cpu_addr  = 12'($urandom_range(0, 15));
      cpu_wdata = $urandom;
      aux_req   = 2'($urandom_range(0, 3));
      aux_wen   = 2'($urandom_range(0, 3));
      aux_addr  = {12'($urandom_range(0, 15)), 12'($urandom_range(0, 15))};
      aux_wdata = {$urandom, $urandom};
      cycle();
    end
    cpu_req = 1'b0; aux_req = '0;
    repeat (3) cycle();

`ifdef DMEM_ARB_STATS_EN
    checkVal("stall_count", DW'(stall_count), DW'(mStalls));
    checkVal("max_wait", DW'(max_wait), DW'(mMaxWait));
`endif

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
